// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_operand_stage_pkg                                               |
// | Shared ALU opcodes and forward-select encoding for the ID/EX stage.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package id_ex_operand_stage_pkg;

    localparam int c_ALUOP_BITS = 4;
    localparam int c_SHAMT_BITS = 5;

    localparam logic [c_ALUOP_BITS-1:0] c_ALU_AND = 4'b0000;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_OR  = 4'b0001;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_NOR = 4'b0010;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_ADD = 4'b0011;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_SUB = 4'b0100;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_SLL = 4'b0101;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_SRL = 4'b0111;
    localparam logic [c_ALUOP_BITS-1:0] c_ALU_LUI = 4'b1111;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage : id_ex_operand_stage_pkg
`default_nettype wire

// File: rtl/id_ex_operand_stage_forward_mux.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | forward_mux                                                           |
// | Per-operand RAW bypass select: EX/MEM beats MEM/WB, index 0 never.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_REG_ADDR = 5
) (
    input  logic [N_REG_ADDR-1:0] i_idx,
    input  logic [N_BITS-1:0]     i_stored,
    input  logic                  i_exmem_regwrite,
    input  logic [N_REG_ADDR-1:0] i_exmem_writereg,
    input  logic [N_BITS-1:0]     i_exmem_data,
    input  logic                  i_memwb_regwrite,
    input  logic [N_REG_ADDR-1:0] i_memwb_writereg,
    input  logic [N_BITS-1:0]     i_memwb_data,
    output fwd_sel_e              o_sel,
    output logic [N_BITS-1:0]     o_data
);

    logic w_idx_nz;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_idx_nz    = (i_idx != '0);
    assign w_hit_exmem = w_idx_nz && i_exmem_regwrite && (i_exmem_writereg == i_idx);
    assign w_hit_memwb = w_idx_nz && i_memwb_regwrite && (i_memwb_writereg == i_idx);

    always_comb begin
        o_sel  = FWD_NONE;
        o_data = i_stored;
        if (w_hit_exmem) begin
            o_sel  = FWD_EXMEM;
            o_data = i_exmem_data;
        end else if (w_hit_memwb) begin
            o_sel  = FWD_MEMWB;
            o_data = i_memwb_data;
        end
    end

endmodule : forward_mux
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_operand_stage                                                   |
// | ID/EX register with EX/MEM and MEM/WB forwarding into the ALU inputs. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_REG_ADDR = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Stall,
    input  logic                    Flush,
    input  logic                    ID_Valid,
    input  logic                    ID_RegWrite,
    input  logic                    ID_ALUSrc,
    input  logic [c_ALUOP_BITS-1:0] ID_ALUOperation,
    input  logic [N_BITS-1:0]       ID_ReadData1,
    input  logic [N_BITS-1:0]       ID_ReadData2,
    input  logic [N_BITS-1:0]       ID_Immediate,
    input  logic [c_SHAMT_BITS-1:0] ID_Shamt,
    input  logic [N_REG_ADDR-1:0]   ID_Rs,
    input  logic [N_REG_ADDR-1:0]   ID_Rt,
    input  logic [N_REG_ADDR-1:0]   ID_WriteReg,
    input  logic                    EXMEM_RegWrite,
    input  logic [N_REG_ADDR-1:0]   EXMEM_WriteReg,
    input  logic [N_BITS-1:0]       EXMEM_ALUResult,
    input  logic                    MEMWB_RegWrite,
    input  logic [N_REG_ADDR-1:0]   MEMWB_WriteReg,
    input  logic [N_BITS-1:0]       MEMWB_WriteData,
    output logic                    EX_Valid,
    output logic                    EX_RegWrite,
    output logic [c_ALUOP_BITS-1:0] EX_ALUOperation,
    output logic [c_SHAMT_BITS-1:0] EX_Shamt,
    output logic [N_REG_ADDR-1:0]   EX_WriteReg,
    output logic [N_BITS-1:0]       EX_A,
    output logic [N_BITS-1:0]       EX_B,
    output logic [N_BITS-1:0]       EX_StoreData
);

    logic                    r_valid;
    logic                    r_regwrite;
    logic                    r_alusrc;
    logic [c_ALUOP_BITS-1:0] r_aluop;
    logic [N_BITS-1:0]       r_rd1;
    logic [N_BITS-1:0]       r_rd2;
    logic [N_BITS-1:0]       r_imm;
    logic [c_SHAMT_BITS-1:0] r_shamt;
    logic [N_REG_ADDR-1:0]   r_rs;
    logic [N_REG_ADDR-1:0]   r_rt;
    logic [N_REG_ADDR-1:0]   r_wreg;

    fwd_sel_e                w_rs_sel;
    fwd_sel_e                w_rt_sel;
    logic [N_BITS-1:0]       w_rs_fwd;
    logic [N_BITS-1:0]       w_rt_fwd;

    forward_mux #(.N_BITS(N_BITS), .N_REG_ADDR(N_REG_ADDR)) u_fwd_rs (
        .i_idx            (r_rs),
        .i_stored         (r_rd1),
        .i_exmem_regwrite (EXMEM_RegWrite),
        .i_exmem_writereg (EXMEM_WriteReg),
        .i_exmem_data     (EXMEM_ALUResult),
        .i_memwb_regwrite (MEMWB_RegWrite),
        .i_memwb_writereg (MEMWB_WriteReg),
        .i_memwb_data     (MEMWB_WriteData),
        .o_sel            (w_rs_sel),
        .o_data           (w_rs_fwd)
    );

    forward_mux #(.N_BITS(N_BITS), .N_REG_ADDR(N_REG_ADDR)) u_fwd_rt (
        .i_idx            (r_rt),
        .i_stored         (r_rd2),
        .i_exmem_regwrite (EXMEM_RegWrite),
        .i_exmem_writereg (EXMEM_WriteReg),
        .i_exmem_data     (EXMEM_ALUResult),
        .i_memwb_regwrite (MEMWB_RegWrite),
        .i_memwb_writereg (MEMWB_WriteReg),
        .i_memwb_data     (MEMWB_WriteData),
        .o_sel            (w_rt_sel),
        .o_data           (w_rt_fwd)
    );

    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_aluop    <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_shamt    <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_wreg     <= '0;
        end else if (Stall) begin
            // Capture any bypassed value so it survives the producer retiring mid-stall.
            if (w_rs_sel != FWD_NONE) r_rd1 <= w_rs_fwd;
            if (w_rt_sel != FWD_NONE) r_rd2 <= w_rt_fwd;
        end else begin
            r_valid    <= ID_Valid;
            r_regwrite <= ID_RegWrite;
            r_alusrc   <= ID_ALUSrc;
            r_aluop    <= ID_ALUOperation;
            r_rd1      <= ID_ReadData1;
            r_rd2      <= ID_ReadData2;
            r_imm      <= ID_Immediate;
            r_shamt    <= ID_Shamt;
            r_rs       <= ID_Rs;
            r_rt       <= ID_Rt;
            r_wreg     <= ID_WriteReg;
        end
    end

    assign EX_Valid        = r_valid;
    assign EX_RegWrite     = r_regwrite;
    assign EX_ALUOperation = r_aluop;
    assign EX_Shamt        = r_shamt;
    assign EX_WriteReg     = r_wreg;
    assign EX_A            = w_rs_fwd;
    assign EX_StoreData    = w_rt_fwd;
    assign EX_B            = r_alusrc ? r_imm : w_rt_fwd;

endmodule : id_ex_operand_stage
`default_nettype wire
